// File: rtl/cmn_arb_lru_matrix_ctrl_pkg.sv
// Shared types and helpers for the cmn matrix arbiter controller.
// Lock FSM encoding and the fixed-priority matrix row pattern.
package cmn_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_lock_state_e;

  localparam int unsigned MAX_W = 32;

  // Row i of the fixed pattern: every lower index blocks i.
  function automatic logic [MAX_W-1:0] fixed_pri_row(input int unsigned i);
    return (MAX_W'(1) << i) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/cmn_arb_lru_matrix_ctrl_if.sv
// Handshake and priority bundle between requesters, arbiter and controller.
// master: requester/arbiter side, slave: the priority controller.
interface cmn_arb_lru_matrix_ctrl_if #(
  parameter int WIDTH = 4
);

  logic                         cfg_fixed_pri;
  logic [WIDTH-1:0]             v_vld_s;
  logic [WIDTH-1:0]             v_last_s;
  logic [WIDTH-1:0]             v_vld_arb;
  logic [WIDTH-1:0]             v_gnt;
  logic [WIDTH-1:0][WIDTH-1:0]  vv_matrix;
  logic                         lock_vld;
  logic                         err;

  modport master (
    output cfg_fixed_pri,
    output v_vld_s,
    output v_last_s,
    output v_gnt,
    input  v_vld_arb,
    input  vv_matrix,
    input  lock_vld,
    input  err
  );

  modport slave (
    input  cfg_fixed_pri,
    input  v_vld_s,
    input  v_last_s,
    input  v_gnt,
    output v_vld_arb,
    output vv_matrix,
    output lock_vld,
    output err
  );

endinterface

// File: rtl/cmn_arb_lru_matrix_ctrl_onehot2bin.sv
// One-hot to binary index encoder.
// Multi-hot input ORs indices; callers flag that case separately.
module cmn_onehot2bin #(
  parameter int WIDTH = 4,
  parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] onehot_i,
  output logic [BW-1:0]    bin_o
);

  // OR together the index of every set bit
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_i[i]) begin
        bin_o = bin_o | BW'(i);
      end
    end
  end

endmodule

// File: rtl/cmn_arb_lru_matrix_ctrl.sv
// LRU priority matrix and packet lock beside a matrix arbiter.
// Matrix [i][j]=1 means j blocks i; diagonal is held at 0.
module cmn_arb_lru_matrix_ctrl
  import cmn_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  cmn_arb_lru_matrix_ctrl_if.slave bus
);

  localparam int IDW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef logic [WIDTH-1:0][WIDTH-1:0] mat_t;

  function automatic mat_t fixed_mat();
    mat_t m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = WIDTH'(fixed_pri_row(i));
    end
    return m;
  endfunction

  localparam mat_t FIXED = fixed_mat();

  arb_lock_state_e  state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   gnt_id;
  logic             err_q;
  mat_t             m_q, m_d;
  logic [WIDTH-1:0] lock_oh;
  logic [WIDTH-1:0] vld_arb;
  logic             multi, single;
  logic             bad_vld, bad_own;
  logic             err_now, ok;
  logic             last_g, lru_upd;

  cmn_onehot2bin #(
    .WIDTH (WIDTH),
    .BW    (IDW)
  ) u_enc (
    .onehot_i (bus.v_gnt),
    .bin_o    (gnt_id)
  );

  assign lock_oh = WIDTH'(1) << lock_id_q;
  assign multi   = |(bus.v_gnt & (bus.v_gnt - WIDTH'(1)));
  assign single  = (|bus.v_gnt) & ~multi;
  assign bad_vld = |(bus.v_gnt & ~vld_arb);
  assign bad_own = (state_q == ARB_LOCKED)
                 & (|(bus.v_gnt & ~lock_oh));
  assign err_now = multi | bad_vld | bad_own;
  assign ok      = single & ~err_now;
  assign last_g  = bus.v_last_s[gnt_id];
  assign lru_upd = ok & last_g & ~bus.cfg_fixed_pri;

  // Lock state and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Lock next state: open on a non-last beat, close on the owner's last
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (ok && !last_g) begin
          state_d   = ARB_LOCKED;
          lock_id_d = gnt_id;
        end
      end
      ARB_LOCKED: begin
        if (ok && last_g) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Lock outputs: mask valids down to the owner while locked
  always_comb begin
    vld_arb      = bus.v_vld_s;
    bus.lock_vld = 1'b0;
    if (state_q == ARB_LOCKED) begin
      vld_arb      = bus.v_vld_s & lock_oh;
      bus.lock_vld = 1'b1;
    end
  end

  // Matrix next state: fixed reload or LRU demotion of the grantee
  always_comb begin
    m_d = m_q;
    if (bus.cfg_fixed_pri) begin
      m_d = FIXED;
    end else if (lru_upd) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_d[gnt_id][i] = 1'b1;
        m_d[i][gnt_id] = 1'b0;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      m_d[i][i] = 1'b0;
    end
  end

  // Matrix and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= FIXED;
      err_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      err_q <= err_q | err_now;
    end
  end

  assign bus.v_vld_arb = vld_arb;
  assign bus.vv_matrix = m_q;
  assign bus.err       = err_q;

endmodule
